// File: rtl/vga_timing_pkg.sv
// Shared constants for the raster timing path (generator and pixel colour stage).
// Holds the default 640x480 mode, the derived line/frame totals and the sync
// window bounds, plus a small window-decode helper.
// No ports.
package vga_timing_pkg;

  localparam int POS_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // True when lo <= pos < hi.
  function automatic logic in_window(input int pos, input int lo, input int hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
//   ce          pixel enable into the generator
//   hpos, vpos  current pixel column / line
//   hsync/vsync active-low syncs
//   visible     inside the active picture
//   line_start, frame_start  one-clock wrap strobes
//   frame_count frames completed (only with VGA_TIMING_FRAME_COUNTER_EN)
// Modports: master = generator, slave = downstream pixel stage.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             ce;
  logic [POS_W-1:0] hpos;
  logic [POS_W-1:0] vpos;
  logic             hsync;
  logic             vsync;
  logic             visible;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TIMING_FRAME_COUNTER_EN
  logic [POS_W-1:0] frame_count;
`endif

  modport master (
    input  ce,
    output hpos, vpos, hsync, vsync, visible, line_start, frame_start
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    , output frame_count
`endif
  );

  modport slave (
    input ce, hpos, vpos, hsync, vsync, visible, line_start, frame_start
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    , input frame_count
`endif
  );

endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo counter used for both raster axes.
//   clk, rst  clock and synchronous active-high reset
//   i_en      advance enable
//   o_count   registered count, 0..MODULUS-1
//   o_next    value the count takes on the next edge (used for co-registered decode)
//   o_wrap    high when this edge wraps MODULUS-1 -> 0
module wrap_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;
  logic             w_last;

  assign w_last  = (r_count == WIDTH'(MODULUS - 1));
  assign o_wrap  = i_en & w_last;
  assign o_count = r_count;

  always_comb begin
    // NOTE: default assignment first, so every path drives o_next and no latch is inferred.
    o_next = r_count;
    if (i_en) o_next = w_last ? '0 : r_count + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= o_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters plus co-registered sync,
// blanking and wrap strobes for a parameterised VGA mode.
//   clk   pixel clock
//   rst   synchronous active-high reset (overrides ce)
//   bus   vga_timing_gen_if.master: ce in; hpos, vpos, hsync, vsync, visible,
//         line_start, frame_start (and frame_count) out
// Optional feature: define VGA_TIMING_FRAME_COUNTER_EN to add a 10-bit
// wrapping count of completed frames.
module vga_timing_gen #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);
  import vga_timing_pkg::*;

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [POS_W-1:0] w_h_count, w_h_next;
  logic [POS_W-1:0] w_v_count, w_v_next;
  logic             w_h_wrap, w_v_wrap;

  logic r_hsync, r_vsync, r_visible, r_line_start, r_frame_start;

  wrap_counter #(.WIDTH(POS_W), .MODULUS(H_TOTAL)) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (bus.ce),
    .o_count (w_h_count),
    .o_next  (w_h_next),
    .o_wrap  (w_h_wrap)
  );

  // The line counter steps only when the pixel counter wraps, so its wrap
  // output is exactly the frame wrap.
  wrap_counter #(.WIDTH(POS_W), .MODULUS(V_TOTAL)) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_h_wrap),
    .o_count (w_v_count),
    .o_next  (w_v_next),
    .o_wrap  (w_v_wrap)
  );

  // Decode from the next counter values so the registered flags line up with
  // the hpos/vpos presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_visible     <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // Wrap flags already include ce, so strobes drop on any non-wrapping edge.
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
      if (bus.ce) begin
        r_hsync   <= !in_window(int'(w_h_next), H_SYNC_START, H_SYNC_END);
        r_vsync   <= !in_window(int'(w_v_next), V_SYNC_START, V_SYNC_END);
        r_visible <= in_window(int'(w_h_next), 0, H_DISPLAY) &&
                     in_window(int'(w_v_next), 0, V_DISPLAY);
      end
    end
  end

  assign bus.hpos        = w_h_count;
  assign bus.vpos        = w_v_count;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.visible     = r_visible;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  logic [POS_W-1:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (rst)           r_frame_count <= '0;
    else if (w_v_wrap) r_frame_count <= r_frame_count + 1'b1;
  end

  assign bus.frame_count = r_frame_count;
`endif

endmodule
